// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with start/valid/busy handshake, HI/LO
// registers, an iterative shift-add multiplier and a restoring divider.
// Optional feature macro: ALU_SEQ_DIV_EN (when undefined, opcodes 10/11
// complete in one cycle with a zero result and the divider is absent).
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_con_Start,
  input  logic [3:0]         i_con_AluCtrl,
  input  logic [WIDTH-1:0]   i_data_A,
  input  logic [WIDTH-1:0]   i_data_B,
  input  logic [SHAMT_W-1:0] i_data_shamt,
  output logic [WIDTH-1:0]   o_data_AluRes,
  output logic               o_con_Zero,
  output logic               o_con_Valid,
  output logic               o_con_Busy,
  output logic [WIDTH-1:0]   o_data_Hi,
  output logic [WIDTH-1:0]   o_data_Lo
);

  // state | meaning
  // IDLE  | waiting for Start; single-cycle ops complete here
  // MUL   | one partial-product bit per cycle
  // DIV   | one quotient bit per cycle (only with the divider built in)
`ifdef ALU_SEQ_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     res_q, hi_q, lo_q;
  logic                 zero_q, valid_q, busy_q;

  logic                 sgn;
  logic [WIDTH-1:0]     a_mag, b_mag, alu_res;
  logic [CNT_W-1:0]     cnt_d;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_mul_d, mul_final;

`ifdef ALU_SEQ_DIV_EN
  logic                 neg_rem_q, dvz_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   acc_div_d;
  logic [WIDTH-1:0]     div_lo, div_hi;
`endif

  // Single-cycle result and operand magnitudes for the iterative units
  always_comb begin
    sgn   = ~i_con_AluCtrl[0];
    a_mag = (sgn && i_data_A[WIDTH-1]) ? -i_data_A : i_data_A;
    b_mag = (sgn && i_data_B[WIDTH-1]) ? -i_data_B : i_data_B;
    alu_res = '0;
    case (i_con_AluCtrl)
      4'd0:    alu_res = i_data_A & i_data_B;
      4'd1:    alu_res = i_data_A | i_data_B;
      4'd2:    alu_res = i_data_A + i_data_B;
      4'd3:    alu_res = i_data_B << i_data_shamt;
      4'd4:    alu_res = i_data_B >> i_data_shamt;
      4'd5:    alu_res = {{(WIDTH-1){1'b0}}, (i_data_A == i_data_B)};
      4'd6:    alu_res = i_data_A - i_data_B;
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_data_A) < $signed(i_data_B))};
      4'd12:   alu_res = ~(i_data_A | i_data_B);
      4'd13:   alu_res = i_data_A ^ i_data_B;
      4'd14:   alu_res = hi_q;
      4'd15:   alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // One iteration of the multiplier (and divider): acc low half holds the
  // multiplier / dividend, which is consumed as the product / quotient fills in
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    acc_mul_d = {mul_sum, acc_q[WIDTH-1:1]};
    mul_final = neg_q ? -acc_mul_d : acc_mul_d;
`ifdef ALU_SEQ_DIV_EN
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    acc_div_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
    div_lo    = dvz_q ? '1 : (neg_q ? -acc_div_d[WIDTH-1:0] : acc_div_d[WIDTH-1:0]);
    div_hi    = dvz_q ? a_q :
                (neg_rem_q ? -acc_div_d[2*WIDTH-1:WIDTH] : acc_div_d[2*WIDTH-1:WIDTH]);
`endif
  end

  // Control FSM with registered result, flags and HI/LO
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
      a_q       <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_con_Start) begin
            cnt_q  <= '0;
            acc_q  <= {{WIDTH{1'b0}}, a_mag};
            opnd_q <= b_mag;
            neg_q  <= sgn && (i_data_A[WIDTH-1] ^ i_data_B[WIDTH-1]);
            case (i_con_AluCtrl)
              4'd8, 4'd9: begin
                state_q <= S_MUL;
                busy_q  <= 1'b1;
              end
`ifdef ALU_SEQ_DIV_EN
              4'd10, 4'd11: begin
                state_q   <= S_DIV;
                busy_q    <= 1'b1;
                neg_rem_q <= sgn && i_data_A[WIDTH-1];
                dvz_q     <= (i_data_B == '0);
                a_q       <= i_data_A;
              end
`endif
              default: begin
                res_q   <= alu_res;
                zero_q  <= (alu_res == '0);
                valid_q <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          acc_q <= acc_mul_d;
          cnt_q <= cnt_d;
          if (cnt_d == CNT_DONE) begin
            hi_q    <= mul_final[2*WIDTH-1:WIDTH];
            lo_q    <= mul_final[WIDTH-1:0];
            res_q   <= mul_final[WIDTH-1:0];
            zero_q  <= (mul_final[WIDTH-1:0] == '0);
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          acc_q <= acc_div_d;
          cnt_q <= cnt_d;
          if (cnt_d == CNT_DONE) begin
            hi_q    <= div_hi;
            lo_q    <= div_lo;
            res_q   <= div_lo;
            zero_q  <= (div_lo == '0);
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data_AluRes = res_q;
  assign o_con_Zero    = zero_q;
  assign o_con_Valid   = valid_q;
  assign o_con_Busy    = busy_q;
  assign o_data_Hi     = hi_q;
  assign o_data_Lo     = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=32) with hand-computed expectations.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [31:0] res, hi, lo;
  logic        zero, valid, busy;

  int n_vec = 0;
  int n_err = 0;

  alu_seq dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_con_Start   (start),
    .i_con_AluCtrl (ctrl),
    .i_data_A      (a),
    .i_data_B      (b),
    .i_data_shamt  (shamt),
    .o_data_AluRes (res),
    .o_con_Zero    (zero),
    .o_con_Valid   (valid),
    .o_con_Busy    (busy),
    .o_data_Hi     (hi),
    .o_data_Lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request on the falling edge, let one rising edge accept it,
  // then drop Start just after the edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sh);
    @(negedge clk);
    start = 1'b1; ctrl = op; a = av; b = bv; shamt = sh;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Bounded wait for Valid; returns number of edges after acceptance.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] av;
    logic [31:0] bv;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];
  int   cyc;
  int   nvalid;
  logic [31:0] lo_seen;

  initial begin
    tbl[0]  = '{4'd0,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000};
    tbl[1]  = '{4'd1,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0};
    tbl[2]  = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000};
    tbl[3]  = '{4'd3,  32'h0,        32'h00000001, 5'd31, 32'h80000000};
    tbl[4]  = '{4'd4,  32'h0,        32'h80000000, 5'd31, 32'h00000001};
    tbl[5]  = '{4'd5,  32'h00000005, 32'h00000005, 5'd0,  32'h00000001};
    tbl[6]  = '{4'd5,  32'h00000005, 32'h00000006, 5'd0,  32'h00000000};
    tbl[7]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001};
    tbl[8]  = '{4'd7,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000};
    tbl[9]  = '{4'd12, 32'hFFFF0000, 32'h0000FFFF, 5'd0,  32'h00000000};
    tbl[10] = '{4'd13, 32'h0000AAAA, 32'h0000FFFF, 5'd0,  32'h00005555};
    tbl[11] = '{4'd6,  32'h00000003, 32'h00000005, 5'd0,  32'hFFFFFFFE};

    rst_n = 1'b0; start = 1'b0; ctrl = '0; a = '0; b = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res",   res,   32'h0);
    chk("rst_zero",  zero,  1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_hi",    hi,    32'h0);
    chk("rst_lo",    lo,    32'h0);
    @(negedge clk); rst_n = 1'b1;

    // ADD then SUB back-to-back, then one idle cycle
    issue(4'd2, 32'd7, 32'd5, 5'd0);
    chk("add_res",   res,   32'd12);
    chk("add_zero",  zero,  1'b0);
    chk("add_valid", valid, 1'b1);
    chk("add_busy",  busy,  1'b0);
    issue(4'd6, 32'd5, 32'd5, 5'd0);
    chk("sub_res",   res,   32'd0);
    chk("sub_zero",  zero,  1'b1);
    chk("sub_valid", valid, 1'b1);
    idle_cycle();
    chk("valid_drop", valid, 1'b0);
    chk("hold_res",   res,   32'd0);

    // Table of single-cycle ops, issued back-to-back
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].op, tbl[i].av, tbl[i].bv, tbl[i].sh);
      chk($sformatf("tbl%0d_res", i),   res,   tbl[i].exp);
      chk($sformatf("tbl%0d_zero", i),  zero,  (tbl[i].exp == 32'h0));
      chk($sformatf("tbl%0d_valid", i), valid, 1'b1);
    end
    chk("tbl_hi", hi, 32'h0);
    chk("tbl_lo", lo, 32'h0);

    // MULT -3 * 4
    issue(4'd8, 32'hFFFFFFFD, 32'd4, 5'd0);
    chk("mult_busy0",  busy,  1'b1);
    chk("mult_valid0", valid, 1'b0);
    a = 32'h12345678; b = 32'h9ABCDEF0;
    wait_valid(cyc);
    chk("mult_cycles", cyc,   32'd32);
    chk("mult_busy1",  busy,  1'b0);
    chk("mult_hi",     hi,    32'hFFFFFFFF);
    chk("mult_lo",     lo,    32'hFFFFFFF4);
    chk("mult_res",    res,   32'hFFFFFFF4);
    chk("mult_zero",   zero,  1'b0);
    idle_cycle();
    chk("mult_vdrop",  valid, 1'b0);
    issue(4'd14, 32'h0, 32'h0, 5'd0);
    chk("mfhi_res", res, 32'hFFFFFFFF);
    issue(4'd15, 32'h0, 32'h0, 5'd0);
    chk("mflo_res", res, 32'hFFFFFFF4);
    chk("mflo_hi",  hi,  32'hFFFFFFFF);

`ifdef ALU_SEQ_DIV_EN
    issue(4'd11, 32'd100, 32'd7, 5'd0);
    chk("divu_busy0", busy, 1'b1);
    wait_valid(cyc);
    chk("divu_cycles", cyc, 32'd32);
    chk("divu_lo",     lo,  32'd14);
    chk("divu_hi",     hi,  32'd2);
    chk("divu_res",    res, 32'd14);
    issue(4'd10, 32'hFFFFFFF9, 32'd2, 5'd0);
    wait_valid(cyc);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    issue(4'd10, 32'd9, 32'd0, 5'd0);
    wait_valid(cyc);
    chk("div0_cycles", cyc,  32'd32);
    chk("div0_lo",     lo,   32'hFFFFFFFF);
    chk("div0_hi",     hi,   32'd9);
    chk("div0_zero",   zero, 1'b0);
    issue(4'd10, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    wait_valid(cyc);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);
`else
    issue(4'd10, 32'd8, 32'd2, 5'd0);
    chk("nodiv_res",   res,   32'h0);
    chk("nodiv_zero",  zero,  1'b1);
    chk("nodiv_valid", valid, 1'b1);
    chk("nodiv_busy",  busy,  1'b0);
    chk("nodiv_hi",    hi,    32'hFFFFFFFF);
    chk("nodiv_lo",    lo,    32'hFFFFFFF4);
    idle_cycle();
    chk("nodiv_vdrop", valid, 1'b0);
`endif

    // MULTU 3*3 with an ADD request during Busy that must be ignored
    issue(4'd9, 32'd3, 32'd3, 5'd0);
    nvalid = 0; lo_seen = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        start = 1'b1; ctrl = 4'd2; a = 32'd100; b = 32'd200;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (valid === 1'b1) begin
        nvalid++;
        lo_seen = lo;
        chk("multu_vcycle", c, 32'd32);
      end
    end
    chk("multu_nvalid", nvalid,  32'd1);
    chk("multu_lo",     lo_seen, 32'd9);
    chk("multu_res",    res,     32'd9);

    // Reset in the middle of a MULT aborts it
    issue(4'd8, 32'd5, 32'd6, 5'd0);
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy",  busy,  1'b0);
    chk("abort_valid", valid, 1'b0);
    chk("abort_hi",    hi,    32'h0);
    chk("abort_lo",    lo,    32'h0);
    chk("abort_res",   res,   32'h0);
    @(negedge clk); rst_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nvalid++;
    end
    chk("abort_novalid", nvalid, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the MIPS datapath ALU.
- Adds a start/valid/busy handshake, HI/LO registers, an iterative shift-add multiplier and a restoring divider.
- Sits in the EX stage. The control unit stalls the pipeline while o_con_Busy is high.
- All single-cycle ALU operations are retained, with a registered result.

Parameters:
- WIDTH, 32, datapath width in bits (power of two, at least 8).
- SHAMT_W, $clog2(WIDTH), shift-amount width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_con_Start  in  1  operation request; sampled only when o_con_Busy=0.
- i_con_AluCtrl  in  4  operation code.
- i_data_A  in  WIDTH  operand A.
- i_data_B  in  WIDTH  operand B.
- i_data_shamt  in  SHAMT_W  shift amount.
- o_data_AluRes  out  WIDTH  registered result.
- o_con_Zero  out  1  registered flag; o_data_AluRes==0.
- o_con_Valid  out  1  one-cycle pulse; result and HI/LO are valid.
- o_con_Busy  out  1  multi-cycle operation in progress.
- o_data_Hi  out  WIDTH  HI register.
- o_data_Lo  out  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset values: while i_rst_n=0 at an edge, the FSM goes to IDLE. o_data_AluRes, o_data_Hi, o_data_Lo and the counter clear to 0. o_con_Zero, o_con_Valid and o_con_Busy clear to 0.
- Reset mid-operation aborts the operation. No Valid pulse is produced.
- Opcodes:
  - 0 AND, 1 OR, 2 ADD (wraps mod 2^WIDTH), 3 SLL B by shamt, 4 SRL B by shamt.
  - 5 EQ (1 if A==B), 6 SUB (wraps), 7 SLT (signed compare, result 1/0).
  - 8 MULT signed, 9 MULTU, 10 DIV signed, 11 DIVU.
  - 12 NOR, 13 XOR, 14 MFHI, 15 MFLO.
- Acceptance: a request is accepted at edge k when i_con_Start=1, o_con_Busy=0 and i_rst_n=1. Start while Busy is ignored, and operands are not re-sampled.
- Operands are latched at acceptance. Changes to the inputs during Busy have no effect.
- Single-cycle ops (all except 8-11): after edge k, o_data_AluRes and o_con_Zero are updated and o_con_Valid=1 for exactly one cycle. HI/LO are unchanged.
- MFHI/MFLO return the HI/LO value as it was at edge k.
- FSM states and transitions:
  - IDLE to MUL on accepted 8/9.
  - IDLE to DIV on accepted 10/11.
  - MUL or DIV to IDLE when the counter reaches WIDTH.
- Multi-cycle timing: o_con_Busy=1 from after edge k until after edge k+WIDTH, i.e. WIDTH cycles.
- Multi-cycle completion, at edge k+WIDTH:
  - HI/LO are written; o_data_AluRes=LO; o_con_Zero reflects LO.
  - o_con_Valid pulses for one cycle and o_con_Busy falls in the same cycle.
  - The next Start can be accepted at edge k+WIDTH+1.
- Multiply: one partial-product bit per cycle on the operand magnitudes. The 2*WIDTH-bit product goes to {HI,LO}. A signed result is negated if the operand signs differ.
- Divide: one quotient bit per cycle on the magnitudes. LO=quotient, HI=remainder.
  - Signed quotient is negated if the signs differ.
  - Signed remainder takes the sign of the dividend.
  - Most-negative / -1 gives LO=most-negative, HI=0.
- Divide by zero (B==0), signed or unsigned: LO=all ones, HI=A, still taking WIDTH cycles.
- Shifts use only i_data_shamt, so a shift of WIDTH or more is impossible by width.
- o_con_Valid and i_con_Start high in the same cycle with Busy=0 is a new acceptance. Back-to-back single-cycle ops achieve throughput 1/cycle.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: opcodes 10/11 run the iterative divider as specified above.
- Undefined: the divider logic and the DIV state are absent. Opcodes 10/11 are single-cycle: o_data_AluRes=0, o_con_Zero=1, Valid pulses after edge k, Busy stays 0, and HI/LO are unchanged.

Test Plan:
- ADD A=7 B=5 Start one cycle -> next cycle AluRes=12, Zero=0, Valid high exactly 1 cycle, Busy=0; then SUB 5-5 back-to-back -> AluRes=0, Zero=1.
- MULT A=0xFFFFFFFD B=4 -> Busy high 32 cycles, then Valid; HI=0xFFFFFFFF, LO=0xFFFFFFF4, AluRes=0xFFFFFFF4; following MFHI -> AluRes=0xFFFFFFFF.
- DIVU A=100 B=7 -> LO=14, HI=2; DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=9 B=0 -> after 32 Busy cycles LO=0xFFFFFFFF, HI=9, Zero=0; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU A=3 B=3, pulse Start again with ADD at cycle 5 -> ADD ignored, only one Valid with LO=9; SLL B=1 shamt=31 -> 0x80000000; SLT A=0xFFFFFFFF B=1 -> 1.
- MULT in progress, i_rst_n=0 at cycle 10 -> next cycle Busy=0, Valid=0, HI=LO=AluRes=0; no Valid ever follows; compile without ALU_SEQ_DIV_EN, DIV 8/2 -> 1-cycle Valid, AluRes=0, HI/LO unchanged.
